inst_mem_loader: RTL and testbench

//  Programs the byte-wide instruction memory from a stream of 32-bit instruction words.

---
 rtl/inst_mem_loader_pkg.sv | 17 +
 rtl/inst_mem_loader_serializer.sv | 38 +++
 rtl/inst_mem_loader.sv | 153 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants for the instruction memory loader and fetch path.
// Holds FSM state encodings and word/byte geometry.
package inst_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = 2;

    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/inst_mem_loader_serializer.sv
// word_byte_serializer: loads a 32-bit word, emits its bytes MSB-first.
// Ports: load/word in, adv steps one byte; byte/idx/last out (all from flops).
module word_byte_serializer
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [31:0]       word_i,
    input  logic              adv_i,
    output logic [7:0]        byte_o,
    output logic [BIDX_W-1:0] idx_o,
    output logic              last_o
);

    logic [31:0]       word_q;
    logic [BIDX_W-1:0] idx_q;

    // Shift register: the current byte is always the top slice, so the
    // byte output comes straight from flops; zeros shift in behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
        end else if (adv_i) begin
            word_q <= {word_q[23:0], 8'h00};
            idx_q  <= idx_q + BIDX_W'(1);
        end
    end

    assign byte_o = word_q[31:24];
    assign idx_o  = idx_q;
    assign last_o = (idx_q == BIDX_LAST);

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: turns a word stream into big-endian byte writes.
// Ports: start/startAddr, word handshake, mem write port, busy/done/err/wordCount.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic              wordValid,
    input  logic [31:0]       wordData,
    input  logic              wordLast,
    output logic              wordReady,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memWData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  wordCount
);

    localparam int AW1 = ADDR_W + 1;

    localparam logic [AW1-1:0] END_MAX = AW1'(MEM_DEPTH - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   maddr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                done_q;
    logic                busy_q;
    logic                rdy_q;
    logic                we_q;
    logic                last_q;

    logic [AW1-1:0]      end_a_d;
    logic                oob_d;
    logic                ser_load_d;
    logic                ser_adv_d;
    logic [7:0]          ser_byte;
    logic [BIDX_W-1:0]   ser_idx;
    logic                ser_last;

    // One extra bit so a word near the top of the address space
    // cannot wrap to a small end address and pass the check.
    assign end_a_d = {1'b0, addr_q} + AW1'(BYTES_PER_WORD - 1);
    assign oob_d   = (end_a_d > END_MAX);

    assign ser_load_d = (state_q == S_ACCEPT) && wordValid && !oob_d;
    assign ser_adv_d  = (state_q == S_WRITE);

    word_byte_serializer u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ser_load_d),
        .word_i (wordData),
        .adv_i  (ser_adv_d),
        .byte_o (ser_byte),
        .idx_o  (ser_idx),
        .last_o (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            maddr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (startAddr[1:0] == 2'b00) begin
                            addr_q  <= startAddr;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            rdy_q   <= 1'b1;
                            state_q <= S_ACCEPT;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (wordValid) begin
                        rdy_q <= 1'b0;
                        if (oob_d) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            last_q  <= wordLast;
                            we_q    <= 1'b1;
                            maddr_q <= addr_q;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (ser_last) begin
                        we_q   <= 1'b0;
                        addr_q <= addr_q + ADDR_W'(BYTES_PER_WORD);
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rdy_q   <= 1'b1;
                            state_q <= S_ACCEPT;
                        end
                    end else begin
                        maddr_q <= addr_q + ADDR_W'(ser_idx) + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wordReady = rdy_q;
    assign memWe     = we_q;
    assign memAddr   = maddr_q;
    assign memWData  = ser_byte;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wordCount = cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table vectors, reset corner, random sessions.
// Expected byte writes come from a plain-arithmetic model of a session.
module tb_inst_mem_loader;

    localparam int MEM_DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] startAddr;
    logic        wordValid;
    logic [31:0] wordData;
    logic        wordLast;
    logic        wordReady;
    logic        memWe;
    logic [31:0] memAddr;
    logic [7:0]  memWData;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] wordCount;

    inst_mem_loader #(
        .ADDR_W    (32),
        .MEM_DEPTH (MEM_DEPTH),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .startAddr (startAddr),
        .wordValid (wordValid),
        .wordData  (wordData),
        .wordLast  (wordLast),
        .wordReady (wordReady),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed activity of the current session
    int          cyc_n = 0;
    logic [31:0] wq_a[$];
    logic [7:0]  wq_d[$];
    int          wq_c[$];
    int          hs[$];
    int          done_cnt;
    int          rdy_cnt;

    // model expectations
    logic [31:0] mw_a[$];
    logic [7:0]  mw_d[$];
    bit          m_err;
    int          m_cnt;

    typedef struct {
        logic [31:0] sa;
        int          n;
        logic [31:0] w[4];
        int          gap;
        bit          inj;
        bit          e_err;
        int          e_cnt;
        int          e_nwr;
    } vec_t;

    vec_t tbl[6];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wordReady) rdy_cnt++;
            if (wordReady && wordValid) hs.push_back(cyc_n);
            if (memWe) begin
                wq_a.push_back(memAddr);
                wq_d.push_back(memWData);
                wq_c.push_back(cyc_n);
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    // Session semantics: aligned start clears count/err; each word
    // needs its 4 bytes inside memory or it is dropped and the session ends.
    function automatic void model(input logic [31:0] sa, input int n,
                                  input logic [31:0] w[4]);
        longint a;
        mw_a.delete();
        mw_d.delete();
        if (sa % 4 != 0) begin
            m_err = 1'b1;
            return;
        end
        m_err = 1'b0;
        m_cnt = 0;
        a = sa;
        for (int i = 0; i < n; i++) begin
            if (a + 3 >= MEM_DEPTH) begin
                m_err = 1'b1;
                return;
            end
            for (int b = 0; b < 4; b++) begin
                mw_a.push_back(32'(a + b));
                mw_d.push_back(8'((w[i] >> (24 - 8 * b)) & 32'hFF));
            end
            a += 4;
            m_cnt++;
        end
    endfunction

    task automatic run_session(input logic [31:0] sa, input int n,
                               input logic [31:0] w[4], input int gap,
                               input bit inj);
        int  cyc;
        bit  stop;
        wq_a.delete();
        wq_d.delete();
        wq_c.delete();
        hs.delete();
        done_cnt = 0;
        rdy_cnt  = 0;
        startAddr = sa;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
            wordValid = 1'b1;
            wordData  = w[i];
            wordLast  = (i == n - 1);
            stop = 1'b0;
            cyc  = 0;
            forever begin
                @(negedge clk);
                if (wordReady) break;
                if (!busy) begin
                    stop = 1'b1;
                    break;
                end
                cyc++;
                if (cyc > 40) begin
                    fail_to("word_handshake");
                    stop = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            wordValid = 1'b0;
            wordLast  = 1'b0;
            if (stop) break;
            if (inj && i == 0) begin
                startAddr = 32'h80;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc > 60) begin
                fail_to("session_end");
                break;
            end
        end
    endtask

    task automatic check_session(input string tag, input logic [31:0] sa,
                                 input int gap);
        int n;
        chk({tag, " nwrites"}, 64'(wq_a.size()), 64'(mw_a.size()));
        n = (wq_a.size() < mw_a.size()) ? wq_a.size() : mw_a.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, " waddr"}, 64'(wq_a[k]), 64'(mw_a[k]));
            chk({tag, " wdata"}, 64'(wq_d[k]), 64'(mw_d[k]));
            if (k / 4 < hs.size())
                chk({tag, " wcycle"}, 64'(wq_c[k]), 64'(hs[k / 4] + 1 + k % 4));
        end
        if (gap == 0) begin
            for (int i = 0; i + 1 < hs.size(); i++)
                chk({tag, " ready_gap"}, 64'(hs[i + 1] - hs[i]), 64'd5);
        end
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " err"}, 64'(err), 64'(m_err));
        chk({tag, " count"}, 64'(wordCount), 64'(m_cnt));
        chk({tag, " busy_end"}, 64'(busy), 64'd0);
        if (sa[1:0] != 2'b00)
            chk({tag, " no_ready"}, 64'(rdy_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] w[4];
        logic [31:0] sa;
        int          n;
        int          cyc;

        tbl[0] = '{32'h00, 1, '{32'h12345678, 32'h0, 32'h0, 32'h0},
                   0, 1'b0, 1'b0, 1, 4};
        tbl[1] = '{32'h10, 3, '{32'hAABBCCDD, 32'h01020304, 32'hDEADBEEF, 32'h0},
                   0, 1'b0, 1'b0, 3, 12};
        tbl[2] = '{32'hFC, 2, '{32'h11223344, 32'h55667788, 32'h0, 32'h0},
                   0, 1'b0, 1'b1, 1, 4};
        tbl[3] = '{32'h02, 1, '{32'h99999999, 32'h0, 32'h0, 32'h0},
                   0, 1'b0, 1'b1, 1, 0};
        tbl[4] = '{32'h100, 1, '{32'h0BADBEEF, 32'h0, 32'h0, 32'h0},
                   0, 1'b0, 1'b1, 0, 0};
        tbl[5] = '{32'h20, 2, '{32'hA1B2C3D4, 32'hE5F60718, 32'h0, 32'h0},
                   10, 1'b1, 1'b0, 2, 8};

        rst_n     = 1'b0;
        start     = 1'b0;
        startAddr = '0;
        wordValid = 1'b0;
        wordData  = '0;
        wordLast  = 1'b0;
        m_cnt     = 0;
        m_err     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst wordReady", 64'(wordReady), 64'd0);
        chk("rst memWe", 64'(memWe), 64'd0);
        chk("rst memAddr", 64'(memAddr), 64'd0);
        chk("rst memWData", 64'(memWData), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst count", 64'(wordCount), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            run_session(tbl[t].sa, tbl[t].n, tbl[t].w, tbl[t].gap, tbl[t].inj);
            model(tbl[t].sa, tbl[t].n, tbl[t].w);
            check_session($sformatf("vec%0d", t), tbl[t].sa, tbl[t].gap);
            chk($sformatf("vec%0d tbl_err", t), 64'(err), 64'(tbl[t].e_err));
            chk($sformatf("vec%0d tbl_count", t), 64'(wordCount), 64'(tbl[t].e_cnt));
            chk($sformatf("vec%0d tbl_nwr", t), 64'(wq_a.size()), 64'(tbl[t].e_nwr));
            @(posedge clk); #1;
        end

        // reset landing on the second byte write of a word
        startAddr = 32'h40;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wordValid = 1'b1;
        wordData  = 32'hCAFEF00D;
        wordLast  = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (wordReady) break;
            cyc++;
            if (cyc > 20) begin
                fail_to("mid_rst handshake");
                break;
            end
        end
        @(posedge clk); #1;
        wordValid = 1'b0;
        wordLast  = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst pre memWe", 64'(memWe), 64'd1);
        chk("mid_rst pre memAddr", 64'(memAddr), 64'h41);
        chk("mid_rst pre memWData", 64'(memWData), 64'hFE);
        rst_n = 1'b0;
        #1;
        chk("mid_rst memWe", 64'(memWe), 64'd0);
        chk("mid_rst busy", 64'(busy), 64'd0);
        chk("mid_rst wordReady", 64'(wordReady), 64'd0);
        chk("mid_rst memAddr", 64'(memAddr), 64'd0);
        chk("mid_rst memWData", 64'(memWData), 64'd0);
        chk("mid_rst done", 64'(done), 64'd0);
        chk("mid_rst err", 64'(err), 64'd0);
        chk("mid_rst count", 64'(wordCount), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk); #1;
        w = '{32'h0BADF00D, 32'h0, 32'h0, 32'h0};
        run_session(32'h20, 1, w, 0, 1'b0);
        model(32'h20, 1, w);
        check_session("post_rst", 32'h20, 0);
        @(posedge clk); #1;

        for (int r = 0; r < 30; r++) begin
            int kind;
            int gap;
            bit inj;
            kind = int'($urandom_range(0, 7));
            if (kind == 0)
                sa = {24'h0, 6'($urandom_range(0, 60)), 2'($urandom_range(1, 3))};
            else if (kind == 1)
                sa = 32'hF0 + 32'(4 * $urandom_range(0, 5));
            else
                sa = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            n   = int'($urandom_range(1, 4));
            gap = int'($urandom_range(0, 3));
            inj = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) w[i] = $urandom;
            run_session(sa, n, w, gap, inj);
            model(sa, n, w);
            check_session($sformatf("rnd%0d", r), sa, gap);
            repeat (int'($urandom_range(1, 3))) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
